// File: rtl/fproc_pkg.sv
// Shared definitions for the fproc arbiter: FSM encoding and default widths.
package fproc_pkg;

    localparam int N_CORES_DEF    = 4;
    localparam int ID_WIDTH_DEF   = 8;
    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/fproc_arbiter_if.sv
// Request/response bus between the arbiter (master) and the shared fproc unit (slave).
interface fproc_if
    import fproc_pkg::*;
#(
    parameter int ID_WIDTH   = ID_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

    logic                  req_valid;
    logic [ID_WIDTH-1:0]   req_id;
    logic                  req_ready;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_data;

    modport master (
        output req_valid,
        output req_id,
        input  req_ready,
        input  resp_valid,
        input  resp_data
    );

    modport slave (
        input  req_valid,
        input  req_id,
        output req_ready,
        output resp_valid,
        output resp_data
    );

endinterface

// File: rtl/rr_priority_select.sv
// Round-robin pick: first set bit of pending strictly after rr_ptr, wrapping around.
module rr_priority_select #(
    parameter int N_CORES = 4,
    parameter int IDX_W   = 2
) (
    input  logic [N_CORES-1:0] pending,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_valid
);

    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cidx;
        grant_idx = '0;
        any_valid = 1'b0;
        cand      = 0;
        cidx      = '0;
        for (int k = 1; k <= N_CORES; k++) begin
            cand = (int'(rr_ptr) + k) % N_CORES;
            cidx = IDX_W'(cand);
            if (!any_valid && pending[cidx]) begin
                any_valid = 1'b1;
                grant_idx = cidx;
            end
        end
    end

endmodule

// File: rtl/fproc_arbiter.sv
// Shares one fproc lookup port among N_CORES cores: one queued request per core,
// round-robin grant, single outstanding transaction, per-core ready pulse + held data.
module fproc_arbiter
    import fproc_pkg::*;
#(
    parameter int N_CORES    = N_CORES_DEF,
    parameter int ID_WIDTH   = ID_WIDTH_DEF,
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_CORES-1:0]            core_req,
    input  logic [N_CORES*ID_WIDTH-1:0]   core_id,
    output logic [N_CORES-1:0]            core_ready,
    output logic [N_CORES*DATA_WIDTH-1:0] core_data,
    fproc_if.master                       fproc,
    output logic                          err_overrun,
    output logic                          err_spurious
);

    localparam int IDX_W = $clog2(N_CORES);

    state_t               state, state_next;
    logic [N_CORES-1:0]   pending;
    logic [ID_WIDTH-1:0]  ids [N_CORES];
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     grant;
    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_any;
    logic                 start_issue;
    logic                 accepted;
    logic                 complete;
    logic [N_CORES-1:0]   done_oh;
    logic                 req_valid_q;
    logic [ID_WIDTH-1:0]  req_id_q;

    rr_priority_select #(
        .N_CORES (N_CORES),
        .IDX_W   (IDX_W)
    ) u_select (
        .pending   (pending),
        .rr_ptr    (rr_ptr),
        .grant_idx (sel_idx),
        .any_valid (sel_any)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        start_issue = 1'b0;
        accepted    = 1'b0;
        complete    = 1'b0;
        done_oh     = '0;
        case (state)
            ST_IDLE: begin
                if (sel_any) begin
                    start_issue = 1'b1;
                    state_next  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (fproc.req_ready) begin
                    accepted   = 1'b1;
                    state_next = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                if (fproc.resp_valid) begin
                    complete   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (complete) done_oh[grant] = 1'b1;
    end

    // A request landing on the completion cycle of the same core re-arms it rather than overrunning.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending     <= '0;
            err_overrun <= 1'b0;
            for (int i = 0; i < N_CORES; i++) ids[i] <= '0;
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                if (core_req[i]) begin
                    if (pending[i] && !done_oh[i]) begin
                        err_overrun <= 1'b1;
                    end else begin
                        pending[i] <= 1'b1;
                        ids[i]     <= core_id[i*ID_WIDTH +: ID_WIDTH];
                    end
                end else if (done_oh[i]) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant        <= '0;
            rr_ptr       <= IDX_W'(N_CORES - 1);
            req_valid_q  <= 1'b0;
            req_id_q     <= '0;
            core_ready   <= '0;
            err_spurious <= 1'b0;
        end else begin
            core_ready <= done_oh;
            if (start_issue) begin
                grant       <= sel_idx;
                req_valid_q <= 1'b1;
                req_id_q    <= ids[sel_idx];
            end
            if (accepted) req_valid_q <= 1'b0;
            if (complete) rr_ptr <= grant;
            if (fproc.resp_valid && state != ST_WAIT_RESP) err_spurious <= 1'b1;
        end
    end

    // Response data is held per core until that core's next completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            core_data <= '0;
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                if (done_oh[i]) core_data[i*DATA_WIDTH +: DATA_WIDTH] <= fproc.resp_data;
            end
        end
    end

    assign fproc.req_valid = req_valid_q;
    assign fproc.req_id    = req_id_q;

endmodule

// File: tb/tb_fproc_arbiter.sv
// Bench for fproc_arbiter: vector table, directed corner sequences, random traffic vs. a transaction model.
module tb_fproc_arbiter;

    localparam int NC = 4;
    localparam int IW = 8;
    localparam int DW = 32;

    logic              clk;
    logic              reset;
    logic [NC-1:0]     core_req;
    logic [NC*IW-1:0]  core_id;
    logic [NC-1:0]     core_ready;
    logic [NC*DW-1:0]  core_data;
    logic              err_overrun;
    logic              err_spurious;

    fproc_if #(.ID_WIDTH(IW), .DATA_WIDTH(DW)) fif ();

    fproc_arbiter #(.N_CORES(NC), .ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .reset        (reset),
        .core_req     (core_req),
        .core_id      (core_id),
        .core_ready   (core_ready),
        .core_data    (core_data),
        .fproc        (fif),
        .err_overrun  (err_overrun),
        .err_spurious (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction-level reference model ----------------
    bit              model_live = 1'b0;
    logic [NC-1:0]   m_pend, m_pend_d1, m_pend_d2;
    logic [IW-1:0]   m_ids [NC];
    logic [NC*DW-1:0] m_data;
    logic [NC-1:0]   m_ready;
    logic            m_ovr, m_spur, m_busy, m_acc;
    int              m_last, m_g;
    logic            prev_valid, prev_ready;
    logic [IW-1:0]   prev_id;

    function automatic int rr_first(input logic [NC-1:0] p, input int last);
        for (int k = 1; k <= NC; k++) begin
            if (p[(last + k) % NC]) return (last + k) % NC;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : model
        logic [NC-1:0] comp_mask;
        int            g_new;
        if (model_live) begin
            chk("m_core_ready", core_ready, m_ready);
            chk("m_core_data", core_data, m_data);
            chk("m_err_overrun", err_overrun, m_ovr);
            chk("m_err_spurious", err_spurious, m_spur);
        end
        if (reset) begin
            m_pend = '0; m_pend_d1 = '0; m_pend_d2 = '0;
            for (int i = 0; i < NC; i++) m_ids[i] = '0;
            m_data = '0; m_ready = '0; m_ovr = 1'b0; m_spur = 1'b0;
            m_busy = 1'b0; m_acc = 1'b0; m_last = NC - 1; m_g = 0;
            prev_valid = 1'b0; prev_ready = 1'b0; prev_id = '0;
            model_live = 1'b1;
        end else if (model_live) begin
            m_pend_d2 = m_pend_d1;
            m_pend_d1 = m_pend;
            if (prev_valid && !prev_ready) begin
                chk("m_valid_hold", fif.req_valid, 1'b1);
                chk("m_id_hold", fif.req_id, prev_id);
            end else if (fif.req_valid) begin
                g_new = rr_first(m_pend_d2, m_last);
                chk("m_grant_exists", g_new >= 0, 1'b1);
                chk("m_no_overlap", m_busy, 1'b0);
                if (g_new >= 0) chk("m_grant_id", fif.req_id, m_ids[g_new]);
                m_g    = (g_new >= 0) ? g_new : 0;
                m_busy = 1'b1;
            end
            comp_mask = '0;
            m_ready   = '0;
            if (fif.resp_valid) begin
                if (m_busy && m_acc) begin
                    comp_mask[m_g]          = 1'b1;
                    m_ready                 = comp_mask;
                    m_data[m_g*DW +: DW]    = fif.resp_data;
                    m_last                  = m_g;
                    m_busy                  = 1'b0;
                    m_acc                   = 1'b0;
                end else begin
                    m_spur = 1'b1;
                end
            end
            if (fif.req_valid && fif.req_ready) m_acc = 1'b1;
            for (int i = 0; i < NC; i++) begin
                if (core_req[i]) begin
                    if (m_pend[i] && !comp_mask[i]) m_ovr = 1'b1;
                    else begin
                        m_pend[i] = 1'b1;
                        m_ids[i]  = core_id[i*IW +: IW];
                    end
                end else if (comp_mask[i]) begin
                    m_pend[i] = 1'b0;
                end
            end
            prev_valid = fif.req_valid;
            prev_ready = fif.req_ready;
            prev_id    = fif.req_id;
        end
    end

    // ---------------- helpers ----------------
    task automatic do_reset;
        reset = 1'b1; core_req = '0; fif.req_ready = 1'b0; fif.resp_valid = 1'b0;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic wait_valid;
        for (int n = 0; n < 40; n++) begin
            if (fif.req_valid) break;
            tick;
        end
        chk("valid_timeout", fif.req_valid, 1'b1);
    endtask

    // Accept the pending request, answer next cycle; returns the ready mask seen.
    task automatic serve(input logic [DW-1:0] data, input logic [NC-1:0] req_at_resp,
                         input logic [NC-1:0] req_after, output logic [NC-1:0] rdy);
        fif.req_ready = 1'b1;
        tick;
        fif.req_ready  = 1'b0;
        fif.resp_valid = 1'b1;
        fif.resp_data  = data;
        core_req       = req_at_resp;
        tick;
        fif.resp_valid = 1'b0;
        core_req       = req_after;
        rdy            = core_ready;
        tick;
        core_req = '0;
        chk("ready_pulse_width", core_ready, '0);
    endtask

    typedef struct {
        int            core;
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        int            ready_delay;
        logic [IW-1:0] exp_id;
        logic [NC-1:0] exp_ready;
        logic [DW-1:0] exp_data;
    } vec_t;

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t          vecs [5];
        logic [NC-1:0] rdy;
        int            order [4];
        bit            waiting;
        int            wait_cnt;
        bit            hs;

        reset = 1'b1; core_req = '0; core_id = '0;
        fif.req_ready = 1'b0; fif.resp_valid = 1'b0; fif.resp_data = '0;

        vecs[0] = '{0, 8'h10, 32'h1111_0000, 0, 8'h10, 4'b0001, 32'h1111_0000};
        vecs[1] = '{2, 8'h33, 32'h2222_3333, 5, 8'h33, 4'b0100, 32'h2222_3333};
        vecs[2] = '{3, 8'hFF, 32'hFFFF_FFFF, 1, 8'hFF, 4'b1000, 32'hFFFF_FFFF};
        vecs[3] = '{1, 8'h00, 32'h0000_0000, 2, 8'h00, 4'b0010, 32'h0000_0000};
        vecs[4] = '{0, 8'h7E, 32'h8000_0001, 3, 8'h7E, 4'b0001, 32'h8000_0001};

        // Reset state and single-request latency
        do_reset;
        chk("rst_core_ready", core_ready, '0);
        chk("rst_core_data", core_data, '0);
        chk("rst_req_valid", fif.req_valid, 1'b0);
        chk("rst_req_id", fif.req_id, '0);
        chk("rst_err_overrun", err_overrun, 1'b0);
        chk("rst_err_spurious", err_spurious, 1'b0);
        core_id[1*IW +: IW] = 8'h05;
        core_req = 4'b0010;
        fif.req_ready = 1'b1;
        tick;
        core_req = '0;
        chk("t1_valid_c1", fif.req_valid, 1'b0);
        tick;
        chk("t1_valid_c2", fif.req_valid, 1'b1);
        chk("t1_id_c2", fif.req_id, 8'h05);
        tick;
        fif.req_ready = 1'b0;
        chk("t1_valid_dropped", fif.req_valid, 1'b0);
        tick;
        fif.resp_valid = 1'b1; fif.resp_data = 32'hDEADBEEF;
        tick;
        fif.resp_valid = 1'b0;
        chk("t1_ready", core_ready, 4'b0010);
        chk("t1_data", core_data[1*DW +: DW], 32'hDEADBEEF);
        tick;
        chk("t1_ready_off", core_ready, '0);
        tick;
        chk("t1_data_held", core_data[1*DW +: DW], 32'hDEADBEEF);

        // Table of single transactions, including a 5-cycle ready stall
        for (int v = 0; v < 5; v++) begin
            core_id[vecs[v].core*IW +: IW] = vecs[v].id;
            core_req = '0;
            core_req[vecs[v].core] = 1'b1;
            tick;
            core_req = '0;
            wait_valid;
            chk("tbl_id", fif.req_id, vecs[v].exp_id);
            for (int d = 0; d < vecs[v].ready_delay; d++) begin
                chk("tbl_stall_valid", fif.req_valid, 1'b1);
                chk("tbl_stall_id", fif.req_id, vecs[v].exp_id);
                tick;
            end
            serve(vecs[v].data, '0, '0, rdy);
            chk("tbl_ready", rdy, vecs[v].exp_ready);
            chk("tbl_data", core_data[vecs[v].core*DW +: DW], vecs[v].exp_data);
        end

        // All four cores at once: grants 0,1,2,3
        do_reset;
        core_id = 32'h04030201;
        core_req = 4'b1111;
        tick;
        core_req = '0;
        for (int k = 0; k < 4; k++) begin
            wait_valid;
            chk("all_id", fif.req_id, IW'(k + 1));
            serve(32'hA000_0000 + k, '0, '0, rdy);
            chk("all_ready", rdy, 4'b0001 << k);
        end
        tick; tick;
        chk("all_idle", fif.req_valid, 1'b0);

        // Fairness: core0 and core2 keep re-requesting on completion
        order[0] = 0; order[1] = 2; order[2] = 0; order[3] = 2;
        core_id = 32'h00C2_00A0;
        core_req = 4'b0101;
        tick;
        core_req = '0;
        for (int j = 0; j < 4; j++) begin
            wait_valid;
            chk("fair_id", fif.req_id, (order[j] == 0) ? 8'hA0 : 8'hC2);
            serve(32'hF000_0000 + j, '0, (j < 2) ? (4'b0001 << order[j]) : 4'b0000, rdy);
            chk("fair_order", rdy, 4'b0001 << order[j]);
        end

        // Request on the completion cycle of the same core re-arms it with the new id
        core_id[1*IW +: IW] = 8'h11;
        core_req = 4'b0010;
        tick;
        core_req = '0;
        wait_valid;
        chk("simul_first_id", fif.req_id, 8'h11);
        core_id[1*IW +: IW] = 8'h22;
        serve(32'h1234_5678, 4'b0010, '0, rdy);
        chk("simul_ready", rdy, 4'b0010);
        wait_valid;
        chk("simul_new_id", fif.req_id, 8'h22);
        serve(32'h8765_4321, '0, '0, rdy);
        chk("simul_no_overrun", err_overrun, 1'b0);

        // Overrun keeps the original id; response in IDLE flags spurious
        do_reset;
        core_id[3*IW +: IW] = 8'h44;
        core_req = 4'b1000;
        tick;
        core_id[3*IW +: IW] = 8'h99;
        tick;
        core_req = '0;
        tick;
        chk("ovr_flag", err_overrun, 1'b1);
        wait_valid;
        chk("ovr_orig_id", fif.req_id, 8'h44);
        serve(32'h0BAD_F00D, '0, '0, rdy);
        chk("ovr_ready", rdy, 4'b1000);
        tick; tick;
        chk("spur_before", err_spurious, 1'b0);
        fif.resp_valid = 1'b1; fif.resp_data = 32'h5555_5555;
        tick;
        fif.resp_valid = 1'b0;
        tick;
        chk("spur_flag", err_spurious, 1'b1);
        chk("spur_no_ready", core_ready, '0);
        chk("ovr_sticky", err_overrun, 1'b1);

        // Reset while waiting for the response, then the late response arrives
        do_reset;
        core_id[0 +: IW] = 8'h66;
        core_req = 4'b0001;
        tick;
        core_req = '0;
        wait_valid;
        fif.req_ready = 1'b1;
        tick;
        fif.req_ready = 1'b0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        fif.resp_valid = 1'b1; fif.resp_data = 32'hCAFE_CAFE;
        tick;
        fif.resp_valid = 1'b0;
        chk("rstmid_no_ready", core_ready, '0);
        chk("rstmid_spur", err_spurious, 1'b1);
        chk("rstmid_data", core_data, '0);
        for (int n = 0; n < 3; n++) begin
            tick;
            chk("rstmid_no_issue", fif.req_valid, 1'b0);
        end

        // Random traffic, checked by the model
        do_reset;
        waiting = 1'b0; wait_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NC; i++) core_req[i] = ($urandom_range(0, 5) == 0);
            core_id       = $urandom;
            fif.req_ready = ($urandom_range(0, 2) != 0);
            fif.resp_data = $urandom;
            fif.resp_valid = 1'b0;
            if (waiting) begin
                if (wait_cnt == 0) begin
                    fif.resp_valid = 1'b1;
                    waiting = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end
            hs = fif.req_valid && fif.req_ready;
            tick;
            if (hs) begin
                waiting  = 1'b1;
                wait_cnt = $urandom_range(0, 3);
            end
        end
        core_req = '0; fif.resp_valid = 1'b0; fif.req_ready = 1'b0;
        tick; tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
